// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types, FSM encoding and helpers for the key-schedule engine and
// the round datapath.
//   word_t / rk_t : 32-bit schedule word / 128-bit round key
//   state_e       : key-schedule FSM states
//   SBOX_TBL      : forward S-box, byte x at SBOX_TBL[2047-8x -: 8]
//   xtime         : GF(2^8) multiply by x (Rcon stepping)
//   nr_of         : number of rounds for a given key width
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] rk_t;

   typedef enum logic {S_IDLE, S_EXPAND} state_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   // Row r holds S-box outputs for inputs 16r .. 16r+15, first entry leftmost.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic int nr_of(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, one byte, purely combinational table lookup.
//   a_i : input byte
//   s_o : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   // Table is stored MSB-first, so entry x sits 8x bits below the top.
   assign s_o = SBOX_TBL[11'd2047 - {a_i, 3'b000} -: 8];

endmodule

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// SubWord: applies the AES S-box to each byte of a 32-bit word. Shared with the
// round datapath.
//   w_i : input word
//   w_o : byte-wise substituted word
// -----------------------------------------------------------------------------
module aes_subword
   import aes_pkg::*;
(
   input  word_t w_i,
   output word_t w_o
);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (w_i[8*b +: 8]),
         .s_o (w_o[8*b +: 8])
      );
   end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_seq
// Iterative AES-128/192/256 key expansion: one schedule word per clock into an
// internal NW-word store; any round key is read combinationally by index.
//   clk, rst_n      : clock, synchronous active-low reset
//   zeroize_i       : (AES_KS_ZEROIZE_EN only) clear store, force IDLE
//   key_in_i        : cipher key, MSB word = w[0]; sampled on accept edge only
//   start_i         : request expansion, accepted when start_i && ready_o
//   ready_o/busy_o  : FSM in IDLE / EXPAND
//   done_o          : one-cycle pulse with the final schedule word written
//   keys_valid_o    : full schedule present and readable
//   rk_idx_i        : round-key index 0..NR
//   rk_data_o       : {w[4k],w[4k+1],w[4k+2],w[4k+3]}, 0 if invalid/out of range
// Optional build macro: AES_KS_ZEROIZE_EN adds the zeroize_i port and clear.
// -----------------------------------------------------------------------------
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef AES_KS_ZEROIZE_EN
   input  logic                zeroize_i,
`endif
   input  logic [KEY_BITS-1:0] key_in_i,
   input  logic                start_i,
   output logic                ready_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                keys_valid_o,
   input  logic [3:0]          rk_idx_i,
   output rk_t                 rk_data_o
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = nr_of(KEY_BITS);
   localparam int NW = 4 * (NR + 1);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
   end

   state_e      state_q, state_d;
   logic [5:0]  i_q, i_d;
   logic [2:0]  j_q, j_d;
   logic [7:0]  rcon_q, rcon_d;
   logic        done_q, done_d;
   logic        kv_q, kv_d;
   logic        load_key, wr_en;

   word_t       w_q [NW];
   word_t       prev_w, old_w, sub_in, sub_out, tmp_w, new_w;

   // ---------------- datapath: w[i] = w[i-NK] ^ t ----------------
   assign prev_w = w_q[i_q - 6'd1];
   assign old_w  = w_q[i_q - 6'(NK)];
   // RotWord only at the start of each NK-word group.
   assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   aes_subword u_subword (
      .w_i (sub_in),
      .w_o (sub_out)
   );

   always_comb begin
      tmp_w = prev_w;
      if (j_q == 3'd0)
         tmp_w = sub_out ^ {rcon_q, 24'h0};
      else if (NK == 8 && j_q == 3'd4)
         tmp_w = sub_out;
   end

   assign new_w = old_w ^ tmp_w;

   // ---------------- FSM / counters ----------------
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      rcon_d   = rcon_q;
      done_d   = 1'b0;
      kv_d     = kv_q;
      load_key = 1'b0;
      wr_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_EXPAND;
               i_d      = 6'(NK);
               j_d      = 3'd0;
               rcon_d   = RCON_INIT;
               kv_d     = 1'b0;
               load_key = 1'b1;
            end
         end
         S_EXPAND: begin
            wr_en = 1'b1;
            i_d   = i_q + 6'd1;
            j_d   = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0)
               rcon_d = xtime(rcon_q);
            if (i_q == 6'(NW - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               kv_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef AES_KS_ZEROIZE_EN
      if (zeroize_i) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         kv_d     = 1'b0;
         load_key = 1'b0;
         wr_en    = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rcon_q  <= RCON_INIT;
         done_q  <= 1'b0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         kv_q    <= kv_d;
      end
   end

   // Word store is deliberately not reset; keys_valid gates every read.
   always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
      if (zeroize_i) begin
         for (int k = 0; k < NW; k++) w_q[k] <= '0;
      end else
`endif
      if (load_key) begin
         for (int k = 0; k < NK; k++) w_q[k] <= key_in_i[KEY_BITS-32*(k+1) +: 32];
      end else if (wr_en) begin
         w_q[i_q] <= new_w;
      end
   end

   // ---------------- outputs ----------------
   assign ready_o      = (state_q == S_IDLE);
   assign busy_o       = (state_q == S_EXPAND);
   assign done_o       = done_q;
   assign keys_valid_o = kv_q;

   always_comb begin
      rk_data_o = '0;
      if (kv_q && rk_idx_i <= 4'(NR)) begin
         for (int b = 0; b < 4; b++)
            rk_data_o[127-32*b -: 32] = w_q[{rk_idx_i, 2'b00} + 6'(b)];
      end
   end

endmodule
